// File: rtl/pe_array_id_loader_pkg.sv
// rtl/pe_array_id_loader_pkg.sv - network encodings, FSM state type and size defaults for the PE-array ID loader
package pe_array_id_loader_pkg;

  localparam int NUM_PE_DEF  = 48;
  localparam int NUM_ROW_DEF = 6;
  localparam int XID_W_DEF   = 5;
  localparam int YID_W_DEF   = 3;

  localparam logic [2:0] NET_FILTER = 3'd0;
  localparam logic [2:0] NET_IFMAP  = 3'd1;
  localparam logic [2:0] NET_IPSUM  = 3'd2;
  localparam logic [2:0] NET_OPSUM  = 3'd3;
  localparam logic [2:0] NET_LN     = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    SEND_Y,
    SEND_X,
    SEND_LN,
    DONE
  } state_t;

endpackage

// File: rtl/pe_array_id_loader_id_entry_mux.sv
// rtl/pe_array_id_loader_id_entry_mux.sv - picks one snapshot ID entry by network, X/Y select and entry index
module id_entry_mux
  import pe_array_id_loader_pkg::*;
#(
  parameter int NUM_PE  = NUM_PE_DEF,
  parameter int NUM_ROW = NUM_ROW_DEF,
  parameter int XID_W   = XID_W_DEF,
  parameter int YID_W   = YID_W_DEF
) (
  input  logic [NUM_PE*XID_W-1:0]  filter_xid,
  input  logic [NUM_PE*XID_W-1:0]  ifmap_xid,
  input  logic [NUM_PE*XID_W-1:0]  ipsum_xid,
  input  logic [NUM_PE*XID_W-1:0]  opsum_xid,
  input  logic [NUM_ROW*YID_W-1:0] filter_yid,
  input  logic [NUM_ROW*YID_W-1:0] ifmap_yid,
  input  logic [NUM_ROW*YID_W-1:0] ipsum_yid,
  input  logic [NUM_ROW*YID_W-1:0] opsum_yid,
  input  logic [2:0]               net,
  input  logic                     is_y,
  input  logic [5:0]               addr,
  output logic [XID_W-1:0]         entry
);

  logic [NUM_PE*XID_W-1:0]  x_bus;
  logic [NUM_ROW*YID_W-1:0] y_bus;
  logic [NUM_PE*XID_W-1:0]  x_sh;
  logic [NUM_ROW*YID_W-1:0] y_sh;

  always_comb begin
    x_bus = filter_xid;
    y_bus = filter_yid;
    case (net)
      NET_IFMAP: begin
        x_bus = ifmap_xid;
        y_bus = ifmap_yid;
      end
      NET_IPSUM: begin
        x_bus = ipsum_xid;
        y_bus = ipsum_yid;
      end
      NET_OPSUM: begin
        x_bus = opsum_xid;
        y_bus = opsum_yid;
      end
      default: begin
        x_bus = filter_xid;
        y_bus = filter_yid;
      end
    endcase
  end

  // Shift-based selection keeps the entry index free of part-select range limits
  assign x_sh  = x_bus >> (int'(addr) * XID_W);
  assign y_sh  = y_bus >> (int'(addr) * YID_W);
  assign entry = is_y ? XID_W'(y_sh[YID_W-1:0]) : x_sh[XID_W-1:0];

endmodule

// File: rtl/pe_array_id_loader.sv
// rtl/pe_array_id_loader.sv - streams snapshotted X/Y IDs and the LN word into the PE array
// Optional: ID_SKIP_DISABLED_EN turns all-ones entries into idle slots with wr_valid low.
module pe_array_id_loader
  import pe_array_id_loader_pkg::*;
#(
  parameter int NUM_PE  = NUM_PE_DEF,
  parameter int NUM_ROW = NUM_ROW_DEF,
  parameter int XID_W   = XID_W_DEF,
  parameter int YID_W   = YID_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_PE*XID_W-1:0]  filter_xid,
  input  logic [NUM_PE*XID_W-1:0]  ifmap_xid,
  input  logic [NUM_PE*XID_W-1:0]  ipsum_xid,
  input  logic [NUM_PE*XID_W-1:0]  opsum_xid,
  input  logic [NUM_ROW*YID_W-1:0] filter_yid,
  input  logic [NUM_ROW*YID_W-1:0] ifmap_yid,
  input  logic [NUM_ROW*YID_W-1:0] ipsum_yid,
  input  logic [NUM_ROW*YID_W-1:0] opsum_yid,
  input  logic [4:0]               ln_config,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [2:0]               wr_net,
  output logic                     wr_is_y,
  output logic [5:0]               wr_addr,
  output logic [XID_W-1:0]         wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [5:0] Y_LAST = 6'(NUM_ROW - 1);
  localparam logic [5:0] X_LAST = 6'(NUM_PE - 1);

  state_t state;

  logic [NUM_PE*XID_W-1:0]  snap_filter_xid;
  logic [NUM_PE*XID_W-1:0]  snap_ifmap_xid;
  logic [NUM_PE*XID_W-1:0]  snap_ipsum_xid;
  logic [NUM_PE*XID_W-1:0]  snap_opsum_xid;
  logic [NUM_ROW*YID_W-1:0] snap_filter_yid;
  logic [NUM_ROW*YID_W-1:0] snap_ifmap_yid;
  logic [NUM_ROW*YID_W-1:0] snap_ipsum_yid;
  logic [NUM_ROW*YID_W-1:0] snap_opsum_yid;
  logic [4:0]               snap_ln;

  state_t           nxt_state;
  logic [2:0]       nxt_net;
  logic             nxt_is_y;
  logic [5:0]       nxt_addr;
  logic [XID_W-1:0] mux_entry;
  logic             nxt_keep;
  logic             first_keep;
  logic             advance;

  // Snapshot is data only; it needs no reset because nothing reads it before a start
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      snap_filter_xid <= filter_xid;
      snap_ifmap_xid  <= ifmap_xid;
      snap_ipsum_xid  <= ipsum_xid;
      snap_opsum_xid  <= opsum_xid;
      snap_filter_yid <= filter_yid;
      snap_ifmap_yid  <= ifmap_yid;
      snap_ipsum_yid  <= ipsum_yid;
      snap_opsum_yid  <= opsum_yid;
      snap_ln         <= ln_config;
    end
  end

  // The registered wr_net/wr_is_y/wr_addr double as the walk pointer
  always_comb begin
    nxt_state = state;
    nxt_net   = wr_net;
    nxt_is_y  = wr_is_y;
    nxt_addr  = wr_addr + 6'd1;
    if (state == SEND_Y && wr_addr == Y_LAST) begin
      nxt_state = SEND_X;
      nxt_is_y  = 1'b0;
      nxt_addr  = 6'd0;
    end else if (state == SEND_X && wr_addr == X_LAST) begin
      nxt_addr = 6'd0;
      if (wr_net == NET_OPSUM) begin
        nxt_state = SEND_LN;
        nxt_net   = NET_LN;
        nxt_is_y  = 1'b0;
      end else begin
        nxt_state = SEND_Y;
        nxt_net   = wr_net + 3'd1;
        nxt_is_y  = 1'b1;
      end
    end
  end

  id_entry_mux #(
    .NUM_PE  (NUM_PE),
    .NUM_ROW (NUM_ROW),
    .XID_W   (XID_W),
    .YID_W   (YID_W)
  ) u_entry_mux (
    .filter_xid (snap_filter_xid),
    .ifmap_xid  (snap_ifmap_xid),
    .ipsum_xid  (snap_ipsum_xid),
    .opsum_xid  (snap_opsum_xid),
    .filter_yid (snap_filter_yid),
    .ifmap_yid  (snap_ifmap_yid),
    .ipsum_yid  (snap_ipsum_yid),
    .opsum_yid  (snap_opsum_yid),
    .net        (nxt_net),
    .is_y       (nxt_is_y),
    .addr       (nxt_addr),
    .entry      (mux_entry)
  );

`ifdef ID_SKIP_DISABLED_EN
  assign nxt_keep   = nxt_is_y ? ~(&mux_entry[YID_W-1:0]) : ~(&mux_entry);
  assign first_keep = ~(&filter_yid[YID_W-1:0]);
`else
  assign nxt_keep   = 1'b1;
  assign first_keep = 1'b1;
`endif

  // An idle (skipped) slot always moves on after one cycle
  assign advance = ~wr_valid | wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_valid <= 1'b0;
      wr_net   <= 3'd0;
      wr_is_y  <= 1'b0;
      wr_addr  <= 6'd0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // First beat comes straight from the live inputs being snapshotted this edge
            state    <= SEND_Y;
            busy     <= 1'b1;
            wr_net   <= NET_FILTER;
            wr_is_y  <= 1'b1;
            wr_addr  <= 6'd0;
            wr_data  <= XID_W'(filter_yid[YID_W-1:0]);
            wr_valid <= first_keep;
          end
        end
        SEND_Y, SEND_X: begin
          if (advance) begin
            state   <= nxt_state;
            wr_net  <= nxt_net;
            wr_is_y <= nxt_is_y;
            wr_addr <= nxt_addr;
            if (nxt_state == SEND_LN) begin
              wr_data  <= XID_W'(snap_ln);
              wr_valid <= 1'b1;
            end else begin
              wr_data  <= mux_entry;
              wr_valid <= nxt_keep;
            end
          end
        end
        SEND_LN: begin
          if (wr_ready) begin
            state    <= DONE;
            wr_valid <= 1'b0;
            wr_net   <= 3'd0;
            wr_is_y  <= 1'b0;
            wr_addr  <= 6'd0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_id_loader.sv
// tb/tb_pe_array_id_loader.sv - scoreboard bench for the PE-array ID loader
module tb_pe_array_id_loader;

  localparam int NUM_PE  = 48;
  localparam int NUM_ROW = 6;
  localparam int XID_W   = 5;
  localparam int YID_W   = 3;
`ifdef ID_SKIP_DISABLED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] net;
    logic       is_y;
    logic [5:0] addr;
    logic [4:0] data;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [NUM_PE*XID_W-1:0]  filter_xid, ifmap_xid, ipsum_xid, opsum_xid;
  logic [NUM_ROW*YID_W-1:0] filter_yid, ifmap_yid, ipsum_yid, opsum_yid;
  logic [4:0]               ln_config;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [2:0]               wr_net;
  logic                     wr_is_y;
  logic [5:0]               wr_addr;
  logic [XID_W-1:0]         wr_data;
  logic                     busy;
  logic                     done;

  logic [4:0] xid [4][NUM_PE];
  logic [2:0] yid [4][NUM_ROW];
  logic [4:0] ln;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t stall_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    first_cyc;
  int    done_cyc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_px
    assign filter_xid[g*XID_W +: XID_W] = xid[0][g];
    assign ifmap_xid[g*XID_W +: XID_W]  = xid[1][g];
    assign ipsum_xid[g*XID_W +: XID_W]  = xid[2][g];
    assign opsum_xid[g*XID_W +: XID_W]  = xid[3][g];
  end
  for (genvar g = 0; g < NUM_ROW; g++) begin : g_py
    assign filter_yid[g*YID_W +: YID_W] = yid[0][g];
    assign ifmap_yid[g*YID_W +: YID_W]  = yid[1][g];
    assign ipsum_yid[g*YID_W +: YID_W]  = yid[2][g];
    assign opsum_yid[g*YID_W +: YID_W]  = yid[3][g];
  end
  assign ln_config = ln;

  pe_array_id_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filter_xid (filter_xid),
    .ifmap_xid  (ifmap_xid),
    .ipsum_xid  (ipsum_xid),
    .opsum_xid  (opsum_xid),
    .filter_yid (filter_yid),
    .ifmap_yid  (ifmap_yid),
    .ipsum_yid  (ipsum_yid),
    .opsum_yid  (opsum_yid),
    .ln_config  (ln_config),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_net     (wr_net),
    .wr_is_y    (wr_is_y),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  // Random IDs avoid the all-ones codes so only deliberate tests exercise skipping
  task automatic scramble();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NUM_PE; i++) xid[n][i] = 5'($urandom_range(0, 30));
      for (int r = 0; r < NUM_ROW; r++) yid[n][r] = 3'($urandom_range(0, 6));
    end
    ln = 5'($urandom_range(0, 31));
  endtask

  task automatic push_expected();
    beat_t b;
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        b = '{net: 3'(n), is_y: 1'b1, addr: 6'(r), data: {2'b00, yid[n][r]}};
        if (!(SKIP && yid[n][r] == 3'd7)) exp_q.push_back(b);
      end
      for (int i = 0; i < NUM_PE; i++) begin
        b = '{net: 3'(n), is_y: 1'b0, addr: 6'(i), data: xid[n][i]};
        if (!(SKIP && xid[n][i] == 5'd31)) exp_q.push_back(b);
      end
    end
    b = '{net: 3'd4, is_y: 1'b0, addr: 6'd0, data: ln};
    exp_q.push_back(b);
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    push_expected();
  endtask

  // Drives wr_ready and start, collects transferred beats and stalled payloads; no checking here
  task automatic run_load(input int budget, input int stop_beats, input int bp_at,
                          input int bp_len, input bit restart);
    int    beats;
    int    bp_left;
    bit    bp_used;
    beat_t cur;
    beats = 0; bp_left = 0; bp_used = 1'b0;
    first_cyc = 0; done_cyc = 0;
    got_q.delete();
    stall_q.delete();
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = restart && (k == 1);
      if (restart && k == 1) scramble();
      if (stop_beats >= 0 && beats == stop_beats) return;
      if (bp_left > 0) begin
        wr_ready = 1'b0;
        bp_left--;
      end else if (!bp_used && bp_at >= 0 && beats == bp_at && wr_valid) begin
        wr_ready = 1'b0;
        bp_left  = bp_len - 1;
        bp_used  = 1'b1;
      end else begin
        wr_ready = 1'b1;
      end
      if (done) begin
        done_cyc = k;
        return;
      end
      cur = '{net: wr_net, is_y: wr_is_y, addr: wr_addr, data: wr_data};
      if (wr_valid && !wr_ready) stall_q.push_back(cur);
      if (wr_valid && wr_ready) begin
        got_q.push_back(cur);
        if (first_cyc == 0) first_cyc = k;
        beats++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
    scramble();
    #1;
    checks++;
    if ({wr_valid, wr_net, wr_is_y, wr_addr, wr_data, busy, done} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {wr_valid, wr_net, wr_is_y, wr_addr, wr_data, busy, done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    beat_t b, e;
    scramble();
    for (int i = 0; i < NUM_PE; i++) xid[0][i] = 5'(i % 32);
    exp_q.delete();
    kick();
    run_load(400, -1, -1, 0, 1'b0);
    checks++;
    if (done_cyc !== 218) begin failures++; $display("FAIL full_done_cycle got=%0d exp=218", done_cyc); end
    checks++;
    if (first_cyc !== 1) begin failures++; $display("FAIL full_first_beat_cycle got=%0d exp=1", first_cyc); end
    checks++;
    if ({busy, wr_valid} !== 2'b00) begin failures++; $display("FAIL full_done_flags busy_valid=%b exp=00", {busy, wr_valid}); end
    e = '{net: 3'd0, is_y: 1'b1, addr: 6'd0, data: {2'b00, yid[0][0]}};
    checks++;
    if (got_q.size() < 7 || got_q[0] !== e) begin failures++; $display("FAIL full_beat0 size=%0d exp=%h", got_q.size(), e); end
    e = '{net: 3'd0, is_y: 1'b0, addr: 6'd0, data: xid[0][0]};
    checks++;
    if (got_q.size() < 7 || got_q[6] !== e) begin failures++; $display("FAIL full_beat7 size=%0d exp=%h", got_q.size(), e); end
    while (got_q.size() > 0) begin
      b = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL full_extra_beat got=%h", b); end
      else begin
        e = exp_q.pop_front();
        if (b !== e) begin failures++; $display("FAIL full_beat got=%h exp=%h", b, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL full_missing_beats got=%0d exp=0", exp_q.size()); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL full_done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_backpressure();
    beat_t b, e;
    scramble();
    exp_q.delete();
    kick();
    run_load(400, -1, 10, 3, 1'b0);
    checks++;
    if (done_cyc !== 221) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=221", done_cyc); end
    checks++;
    if (stall_q.size() !== 3) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall_q.size()); end
    if (got_q.size() > 10) begin
      for (int i = 0; i < stall_q.size(); i++) begin
        checks++;
        if (stall_q[i] !== got_q[10]) begin failures++; $display("FAIL bp_hold got=%h exp=%h", stall_q[i], got_q[10]); end
      end
    end
    while (got_q.size() > 0) begin
      b = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra_beat got=%h", b); end
      else begin
        e = exp_q.pop_front();
        if (b !== e) begin failures++; $display("FAIL bp_beat got=%h exp=%h", b, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_missing_beats got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_snapshot();
    beat_t b, e;
    int    stray;
    scramble();
    exp_q.delete();
    kick();
    run_load(400, -1, -1, 0, 1'b1);
    checks++;
    if (done_cyc !== 218) begin failures++; $display("FAIL snap_done_cycle got=%0d exp=218", done_cyc); end
    while (got_q.size() > 0) begin
      b = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL snap_extra_beat got=%h", b); end
      else begin
        e = exp_q.pop_front();
        if (b !== e) begin failures++; $display("FAIL snap_beat got=%h exp=%h", b, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL snap_missing_beats got=%0d exp=0", exp_q.size()); end
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || wr_valid || done) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL snap_second_load active_cycles=%0d exp=0", stray); end
  endtask

  task automatic test_reset_midload();
    beat_t b, e;
    scramble();
    exp_q.delete();
    kick();
    run_load(400, 50, -1, 0, 1'b0);
    checks++;
    if (got_q.size() !== 50) begin failures++; $display("FAIL rst_beats_before got=%0d exp=50", got_q.size()); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wr_valid, wr_net, wr_is_y, wr_addr, wr_data, busy, done} !== 18'd0) begin
      failures++;
      $display("FAIL rst_async_outputs got=%h exp=0", {wr_valid, wr_net, wr_is_y, wr_addr, wr_data, busy, done});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({wr_valid, busy} !== 2'b00) begin failures++; $display("FAIL rst_held_outputs got=%b exp=00", {wr_valid, busy}); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    scramble();
    kick();
    run_load(400, -1, -1, 0, 1'b0);
    checks++;
    if (done_cyc !== 218) begin failures++; $display("FAIL rst_reload_done_cycle got=%0d exp=218", done_cyc); end
    e = '{net: 3'd0, is_y: 1'b1, addr: 6'd0, data: {2'b00, yid[0][0]}};
    checks++;
    if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL rst_reload_first size=%0d exp=%h", got_q.size(), e); end
    while (got_q.size() > 0) begin
      b = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL rst_extra_beat got=%h", b); end
      else begin
        e = exp_q.pop_front();
        if (b !== e) begin failures++; $display("FAIL rst_beat got=%h exp=%h", b, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rst_missing_beats got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_disabled_entries();
    beat_t b, e;
    int    ny, nx;
    scramble();
    for (int r = 0; r < NUM_ROW; r++) yid[2][r] = (r == 0) ? 3'd0 : 3'd7;
    for (int i = 0; i < NUM_PE; i++) xid[2][i] = (i < 8) ? 5'(i) : 5'd31;
    exp_q.delete();
    kick();
    run_load(400, -1, -1, 0, 1'b0);
    checks++;
    if (done_cyc !== 218) begin failures++; $display("FAIL skip_done_cycle got=%0d exp=218", done_cyc); end
    ny = 0; nx = 0;
    foreach (got_q[i]) begin
      if (got_q[i].net == 3'd2 && got_q[i].is_y) ny++;
      if (got_q[i].net == 3'd2 && !got_q[i].is_y) nx++;
    end
    checks++;
    if (ny !== (SKIP ? 1 : 6)) begin failures++; $display("FAIL skip_ipsum_y_beats got=%0d exp=%0d", ny, SKIP ? 1 : 6); end
    checks++;
    if (nx !== (SKIP ? 8 : 48)) begin failures++; $display("FAIL skip_ipsum_x_beats got=%0d exp=%0d", nx, SKIP ? 8 : 48); end
    while (got_q.size() > 0) begin
      b = got_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL skip_extra_beat got=%h", b); end
      else begin
        e = exp_q.pop_front();
        if (b !== e) begin failures++; $display("FAIL skip_beat got=%h exp=%h", b, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL skip_missing_beats got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_snapshot();
    test_reset_midload();
    test_disabled_entries();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
